// File: rtl/pkt_rx_loopback.sv
// pkt_rx_loopback
//   Store-and-forward loopback between the XGE MAC packet RX and TX ports.
//   Whole frames are read from the RX side into a local buffer. A frame that
//   ends with pkt_rx_err is dropped. Every other frame is replayed on the TX
//   side, and the TX side holds off while pkt_tx_full is high.
//
// Ports
//   clk_156m25, reset_156m25_n : clock, asynchronous active-low reset
//   loop_en                    : 1 = accept new frames
//   pkt_rx_avail/ren/data/val/sop/eop/mod/err : MAC RX packet interface
//   pkt_tx_data/val/sop/eop/mod, pkt_tx_full  : MAC TX packet interface
//   stat_fwd_cnt, stat_drop_cnt               : saturating frame counters
module pkt_rx_loopback #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_156m25,
    input  logic             reset_156m25_n,
    input  logic             loop_en,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_val,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic [2:0]       pkt_rx_mod,
    input  logic             pkt_rx_err,
    output logic [63:0]      pkt_tx_data,
    output logic             pkt_tx_val,
    output logic             pkt_tx_sop,
    output logic             pkt_tx_eop,
    output logic [2:0]       pkt_tx_mod,
    input  logic             pkt_tx_full,
    output logic [CNT_W-1:0] stat_fwd_cnt,
    output logic [CNT_W-1:0] stat_drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    // One extra pointer bit tells a full buffer apart from an empty one
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FRAME = 2'd1;
    localparam logic [1:0] R_DROP  = 2'd2;

    localparam logic T_IDLE = 1'b0;
    localparam logic T_SEND = 1'b1;

    // Entry layout: {data[63:0], sop, eop, mod[2:0]}
    logic [68:0] mem [DEPTH];

    logic [1:0]       rx_state_q, rx_state_d;
    logic             tx_state_q, tx_state_d;
    logic             in_frame_q, in_frame_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    fs_ptr_q, fs_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [PW-1:0]    used_nxt, free_nxt, wr_addr;
    logic             ren_q, ren_d;
    logic             wr_en, take_word, commit;
    logic [1:0]       drop_inc;
    logic [68:0]      tx_word;
    logic             tx_fire, tx_last;
    logic [63:0]      tx_data_q;
    logic             tx_val_q, tx_sop_q, tx_eop_q;
    logic [2:0]       tx_mod_q;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W:0]   drop_sum;

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    always_comb begin
        rx_state_d = rx_state_q;
        wr_ptr_d   = wr_ptr_q;
        fs_ptr_d   = fs_ptr_q;
        in_frame_d = in_frame_q;
        wr_addr    = wr_ptr_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop_inc   = 2'd0;
        ren_d      = 1'b0;

        // A word is kept only when it opens a frame or continues one. This
        // also catches the single word that can arrive after ren drops.
        take_word = pkt_rx_val && (rx_state_q != R_DROP) && (pkt_rx_sop || in_frame_q);

        if (take_word) begin
            if (pkt_rx_sop) begin
                // sop inside an open frame: rewind and drop the old frame
                if (in_frame_q) begin
                    wr_addr  = fs_ptr_q;
                    drop_inc = 2'd1;
                end
                fs_ptr_d = wr_addr;
            end
            wr_en    = 1'b1;
            wr_ptr_d = wr_addr + PW'(1);
            if (pkt_rx_eop) begin
                in_frame_d = 1'b0;
                rx_state_d = R_IDLE;
                if (pkt_rx_err) begin
                    wr_en    = 1'b0;
                    wr_ptr_d = fs_ptr_d;
                    drop_inc = drop_inc + 2'd1;
                end else begin
                    commit = 1'b1;
                end
            end else begin
                in_frame_d = 1'b1;
                rx_state_d = R_FRAME;
            end
        end else if (rx_state_q == R_DROP) begin
            if (pkt_rx_val && pkt_rx_eop) begin
                rx_state_d = R_IDLE;
            end
        end else if (rx_state_q == R_IDLE) begin
            if (loop_en && pkt_rx_avail) begin
                rx_state_d = R_FRAME;
            end
        end

        used_nxt = wr_ptr_d - rd_ptr_q;
        free_nxt = PW'(DEPTH) - used_nxt;

        // With nothing committed, the open frame alone has filled the
        // buffer and can never be completed.
        if (in_frame_d && (frame_cnt_q == '0) && (free_nxt < PW'(2))) begin
            wr_ptr_d   = fs_ptr_d;
            in_frame_d = 1'b0;
            drop_inc   = drop_inc + 2'd1;
            rx_state_d = R_DROP;
        end

        // Two free slots are needed: one for the word already in flight and
        // one for the word this read requests.
        case (rx_state_d)
            R_FRAME: ren_d = (free_nxt >= PW'(2));
            R_DROP:  ren_d = 1'b1;
            default: ren_d = 1'b0;
        endcase

        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(drop_inc);
        drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk_156m25) begin
        if (wr_en) begin
            mem[wr_addr[AW-1:0]] <= {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod};
        end
    end

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    always_comb begin
        tx_word    = mem[rd_ptr_q[AW-1:0]];
        tx_fire    = (tx_state_q == T_SEND) && !pkt_tx_full;
        tx_last    = tx_fire && tx_word[3];
        rd_ptr_d   = rd_ptr_q + PW'(tx_fire);
        tx_state_d = tx_state_q;
        if (tx_state_q == T_IDLE) begin
            if (frame_cnt_q != '0) begin
                tx_state_d = T_SEND;
            end
        end else if (tx_last) begin
            tx_state_d = T_IDLE;
        end
        // A commit and a TX eop on the same edge cancel out
        frame_cnt_d = frame_cnt_q + PW'(commit) - PW'(tx_last);
        fwd_cnt_d   = fwd_cnt_q;
        if (tx_last && !(&fwd_cnt_q)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            rx_state_q  <= R_IDLE;
            tx_state_q  <= T_IDLE;
            in_frame_q  <= 1'b0;
            wr_ptr_q    <= '0;
            fs_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            ren_q       <= 1'b0;
            tx_data_q   <= '0;
            tx_val_q    <= 1'b0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            tx_mod_q    <= '0;
            fwd_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            in_frame_q  <= in_frame_d;
            wr_ptr_q    <= wr_ptr_d;
            fs_ptr_q    <= fs_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            ren_q       <= ren_d;
            fwd_cnt_q   <= fwd_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            tx_val_q    <= tx_fire;
            // Word fields only move together with a strobe
            if (tx_fire) begin
                tx_data_q <= tx_word[68:5];
                tx_sop_q  <= tx_word[4];
                tx_eop_q  <= tx_word[3];
                tx_mod_q  <= tx_word[2:0];
            end
        end
    end

    assign pkt_rx_ren    = ren_q;
    assign pkt_tx_data   = tx_data_q;
    assign pkt_tx_val    = tx_val_q;
    assign pkt_tx_sop    = tx_sop_q;
    assign pkt_tx_eop    = tx_eop_q;
    assign pkt_tx_mod    = tx_mod_q;
    assign stat_fwd_cnt  = fwd_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pkt_rx_loopback.sv
// Bench for pkt_rx_loopback: a MAC RX model feeds frames, and a scoreboard
// holds the words expected on TX, in order.
module tb_pkt_rx_loopback;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } rx_word_t;

    logic             clk_156m25 = 1'b0;
    logic             reset_156m25_n;
    logic             loop_en;
    logic             pkt_rx_avail;
    logic             pkt_rx_ren;
    logic [63:0]      pkt_rx_data;
    logic             pkt_rx_val;
    logic             pkt_rx_sop;
    logic             pkt_rx_eop;
    logic [2:0]       pkt_rx_mod;
    logic             pkt_rx_err;
    logic [63:0]      pkt_tx_data;
    logic             pkt_tx_val;
    logic             pkt_tx_sop;
    logic             pkt_tx_eop;
    logic [2:0]       pkt_tx_mod;
    logic             pkt_tx_full;
    logic [CNT_W-1:0] stat_fwd_cnt;
    logic [CNT_W-1:0] stat_drop_cnt;

    rx_word_t    mac_q[$];
    logic [68:0] exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned tx_words = 0;
    int unsigned exp_fwd  = 0;
    int unsigned exp_drop = 0;
    logic        full_force = 1'b0;
    logic        full_rand  = 1'b0;
    logic        full_prev  = 1'b0;

    pkt_rx_loopback #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .loop_en        (loop_en),
        .pkt_rx_avail   (pkt_rx_avail),
        .pkt_rx_ren     (pkt_rx_ren),
        .pkt_rx_data    (pkt_rx_data),
        .pkt_rx_val     (pkt_rx_val),
        .pkt_rx_sop     (pkt_rx_sop),
        .pkt_rx_eop     (pkt_rx_eop),
        .pkt_rx_mod     (pkt_rx_mod),
        .pkt_rx_err     (pkt_rx_err),
        .pkt_tx_data    (pkt_tx_data),
        .pkt_tx_val     (pkt_tx_val),
        .pkt_tx_sop     (pkt_tx_sop),
        .pkt_tx_eop     (pkt_tx_eop),
        .pkt_tx_mod     (pkt_tx_mod),
        .pkt_tx_full    (pkt_tx_full),
        .stat_fwd_cnt   (stat_fwd_cnt),
        .stat_drop_cnt  (stat_drop_cnt)
    );

    always #5 clk_156m25 = ~clk_156m25;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Queue one frame on the MAC; good frames also go to the scoreboard
    task automatic send_frame(input int len, input logic [2:0] mod, input logic err,
                              input logic expect_out);
        for (int i = 0; i < len; i++) begin
            rx_word_t w;
            w.data = {$urandom, $urandom};
            w.sop  = (i == 0);
            w.eop  = (i == len - 1);
            w.mod  = (i == len - 1) ? mod : 3'd0;
            w.err  = err && (i == len - 1);
            mac_q.push_back(w);
            if (expect_out) begin
                exp_q.push_back({w.data, w.sop, w.eop, w.mod});
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while ((mac_q.size() != 0 || exp_q.size() != 0) && n < 150000) begin
            @(negedge clk_156m25);
            n++;
        end
        check_eq(tag, 128'(mac_q.size() + exp_q.size()), 128'(0));
        repeat (8) @(negedge clk_156m25);
    endtask

    task automatic wait_tx_words(input int unsigned target, input string tag);
        int unsigned n = 0;
        while (tx_words < target && n < 5000) begin
            @(negedge clk_156m25);
            n++;
        end
        check_eq(tag, 128'(tx_words >= target), 128'(1));
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_fwd"}, 128'(stat_fwd_cnt), 128'(exp_fwd));
        check_eq({tag, "_drop"}, 128'(stat_drop_cnt), 128'(exp_drop));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ren"}, 128'(pkt_rx_ren), 128'(0));
        check_eq({tag, "_tx_val"}, 128'(pkt_tx_val), 128'(0));
        check_eq({tag, "_tx_word"}, 128'({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}),
                 128'(0));
        check_counters(tag);
    endtask

    // MAC RX model: a word follows one cycle after a cycle with ren high
    initial begin
        logic r;
        rx_word_t w;
        pkt_rx_avail = 1'b0;
        pkt_rx_data  = '0;
        pkt_rx_val   = 1'b0;
        pkt_rx_sop   = 1'b0;
        pkt_rx_eop   = 1'b0;
        pkt_rx_mod   = '0;
        pkt_rx_err   = 1'b0;
        forever begin
            @(negedge clk_156m25);
            r = pkt_rx_ren;
            @(posedge clk_156m25);
            #1;
            if (r && mac_q.size() != 0) begin
                w = mac_q.pop_front();
                pkt_rx_data = w.data;
                pkt_rx_val  = 1'b1;
                pkt_rx_sop  = w.sop;
                pkt_rx_eop  = w.eop;
                pkt_rx_mod  = w.mod;
                pkt_rx_err  = w.err;
            end else begin
                pkt_rx_val = 1'b0;
                pkt_rx_sop = 1'b0;
                pkt_rx_eop = 1'b0;
                pkt_rx_err = 1'b0;
            end
            pkt_rx_avail = (mac_q.size() != 0);
        end
    end

    // TX backpressure driver
    initial begin
        pkt_tx_full = 1'b0;
        forever begin
            @(posedge clk_156m25);
            #1;
            pkt_tx_full = full_rand ? ($urandom_range(0, 15) == 0) : full_force;
        end
    end

    // TX monitor: full_prev holds the full level the DUT saw at this cycle's edge
    initial begin
        forever begin
            @(negedge clk_156m25);
            if (reset_156m25_n && pkt_tx_val) begin
                check_eq("tx_after_full", 128'(full_prev), 128'(0));
                check_eq("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    check_eq("tx_word",
                             128'({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}),
                             128'(exp_q.pop_front()));
                end
                tx_words++;
            end
            full_prev = pkt_tx_full;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned w0;
        reset_156m25_n = 1'b0;
        loop_en        = 1'b0;
        repeat (3) @(posedge clk_156m25);
        @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        @(negedge clk_156m25);
        check_outputs_zero("reset");
        loop_en = 1'b1;

        // 1: simple 3-word frame
        send_frame(3, 3'd5, 1'b0, 1'b1);
        wait_drain("t1_drain");
        exp_fwd = 1;
        check_counters("t1");

        // 2: errored frame dropped, then a 1-word frame forwarded
        send_frame(3, 3'd2, 1'b1, 1'b0);
        send_frame(1, 3'd0, 1'b0, 1'b1);
        wait_drain("t2_drain");
        exp_fwd  = 2;
        exp_drop = 1;
        check_counters("t2");

        // 3: TX stall of 20 cycles mid-frame
        w0 = tx_words;
        send_frame(40, 3'd3, 1'b0, 1'b1);
        wait_tx_words(w0 + 10, "t3_started");
        @(posedge clk_156m25);
        full_force = 1'b1;
        repeat (2) @(negedge clk_156m25);
        w0 = tx_words;
        repeat (16) @(negedge clk_156m25);
        check_eq("t3_stall_quiet", 128'(tx_words), 128'(w0));
        repeat (3) @(posedge clk_156m25);
        full_force = 1'b0;
        wait_drain("t3_drain");
        exp_fwd = 3;
        check_counters("t3");

        // 4: frame longer than the buffer is dropped, next frame intact
        send_frame(DEPTH + 24, 3'd1, 1'b0, 1'b0);
        send_frame(4, 3'd6, 1'b0, 1'b1);
        wait_drain("t4_drain");
        exp_fwd  = 4;
        exp_drop = 2;
        check_counters("t4");

        // 5: 1000 back-to-back 64-word frames under random backpressure
        full_rand = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            send_frame(64, 3'($urandom_range(0, 7)), 1'b0, 1'b1);
        end
        wait_drain("t5_drain");
        full_rand = 1'b0;
        exp_fwd   = 1004;
        check_counters("t5");

        // 6: reset while one frame is on TX and the next is on RX
        w0 = tx_words;
        send_frame(20, 3'd4, 1'b0, 1'b1);
        send_frame(100, 3'd7, 1'b0, 1'b1);
        wait_tx_words(w0 + 5, "t6_started");
        @(posedge clk_156m25);
        #2;
        reset_156m25_n = 1'b0;
        mac_q.delete();
        exp_q.delete();
        #1;
        exp_fwd  = 0;
        exp_drop = 0;
        check_outputs_zero("t6_in_reset");
        repeat (3) @(posedge clk_156m25);
        @(negedge clk_156m25);
        reset_156m25_n = 1'b1;
        send_frame(5, 3'd3, 1'b0, 1'b1);
        wait_drain("t6_drain");
        exp_fwd = 1;
        check_counters("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
